// File: rtl/axis_width_packer_pkg.sv
// Shared helpers for the narrow-to-wide AXI-stream packer.
// Covers beats-per-word, counter and fill widths, and lane placement.
package axis_width_packer_pkg;

  // Input beats that make up one output word.
  function automatic int unsigned beats_per_word(input int unsigned in_w,
                                                 input int unsigned out_w);
    return out_w / in_w;
  endfunction

  // Lane counter width; at least one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Width able to hold a fill count of 0..n.
  function automatic int unsigned fill_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Bit offset of the low end of lane `lane` inside the output word.
  function automatic int unsigned lane_lsb(input int unsigned lane,
                                           input int unsigned in_w,
                                           input int unsigned out_w,
                                           input bit          msb_first);
    return msb_first ? out_w - (lane + 1) * in_w : lane * in_w;
  endfunction

endpackage

// File: rtl/axis_width_packer_if.sv
// Stream bundle for axis_width_packer.
// slave: the packer's view; master: the view of whatever drives it.
// The last/fill sideband exists only with AXIS_WIDTH_PACKER_LAST_EN.
interface axis_width_packer_if
  import axis_width_packer_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH  = 1,
  parameter int unsigned OUTPUT_WIDTH = 8
);
  localparam int unsigned Beats = beats_per_word(INPUT_WIDTH, OUTPUT_WIDTH);
  localparam int unsigned FillW = fill_width(Beats);

  logic                    s_valid_i;
  logic [INPUT_WIDTH-1:0]  s_data_i;
  logic                    s_ready_o;
  logic                    m_ready_i;
  logic                    m_valid_o;
  logic [OUTPUT_WIDTH-1:0] m_data_o;
`ifdef AXIS_WIDTH_PACKER_LAST_EN
  logic                    s_last_i;
  logic                    m_last_o;
  logic [FillW-1:0]        m_fill_o;
`endif

  modport slave (
    input  s_valid_i, s_data_i, m_ready_i,
`ifdef AXIS_WIDTH_PACKER_LAST_EN
    input  s_last_i,
    output m_last_o, m_fill_o,
`endif
    output s_ready_o, m_valid_o, m_data_o
  );

  modport master (
    output s_valid_i, s_data_i, m_ready_i,
`ifdef AXIS_WIDTH_PACKER_LAST_EN
    output s_last_i,
    input  m_last_o, m_fill_o,
`endif
    input  s_ready_o, m_valid_o, m_data_o
  );

endinterface

// File: rtl/axis_width_packer_lane_counter.sv
// Lane index for the packer: counts 0..N-1 on each accepted beat.
// Wraps after the terminal count, or early on a synchronous clear.
module axis_width_packer_lane_counter #(
  parameter int unsigned N    = 8,
  parameter int unsigned CntW = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inc_i,
  input  logic            clr_i,
  output logic [CntW-1:0] cnt_o,
  output logic            tc_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tc_o  = (cnt_q == CntW'(N - 1));
  assign cnt_o = cnt_q;

  // Advance on accept; return to lane 0 at the end of a word.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) begin
      cnt_d = (tc_o || clr_i) ? '0 : cnt_q + CntW'(1);
    end
  end

  // Lane index register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/axis_width_packer.sv
// Narrow-to-wide AXI-stream packer: N input beats become one output word.
// Double-buffered (accumulator + output register) so it takes one beat per
// cycle under continuous m_ready; s_ready is driven from a register only.
// Optional macro AXIS_WIDTH_PACKER_LAST_EN adds s_last/m_last/m_fill so a
// packet end can close a partial word early.
module axis_width_packer
  import axis_width_packer_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH  = 1,
  parameter int unsigned OUTPUT_WIDTH = 8,
  parameter bit          MSB_FIRST    = 1'b1
) (
  input logic                clk,
  input logic                reset,
  axis_width_packer_if.slave bus
);

  localparam int unsigned Beats = beats_per_word(INPUT_WIDTH, OUTPUT_WIDTH);
  localparam int unsigned CntW  = cnt_width(Beats);

  logic [OUTPUT_WIDTH-1:0] acc_q, acc_d, out_q, out_d, merged;
  logic                    acc_full_q, acc_full_d, m_valid_q, m_valid_d;
  logic                    accept, out_free, beat_last, word_done, tc;
  logic                    move_acc, load_merged, park_merged;
  logic [CntW-1:0]         cnt;
  int unsigned             lane_idx;

  assign accept   = bus.s_valid_i && !acc_full_q;
  assign out_free = !m_valid_q || bus.m_ready_i;

`ifdef AXIS_WIDTH_PACKER_LAST_EN
  assign beat_last = bus.s_last_i;
`else
  assign beat_last = 1'b0;
`endif

  assign word_done   = accept && (tc || beat_last);
  // A parked word always has priority; no beat can arrive while it is parked.
  assign move_acc    = acc_full_q && out_free;
  assign load_merged = word_done && out_free;
  assign park_merged = word_done && !out_free;

  axis_width_packer_lane_counter #(
    .N    (Beats),
    .CntW (CntW)
  ) u_lane_counter (
    .clk   (clk),
    .reset (reset),
    .inc_i (accept),
    .clr_i (beat_last),
    .cnt_o (cnt),
    .tc_o  (tc)
  );

  assign lane_idx = 32'(cnt);

  // Drop the incoming beat into its lane; unfilled lanes of acc are zero.
  always_comb begin
    merged = acc_q | (OUTPUT_WIDTH'(bus.s_data_i)
                      << lane_lsb(lane_idx, INPUT_WIDTH, OUTPUT_WIDTH, MSB_FIRST));
  end

  // Next-state for accumulator, parked flag and output register.
  always_comb begin
    acc_d      = acc_q;
    out_d      = out_q;
    acc_full_d = acc_full_q;
    m_valid_d  = m_valid_q;
    if (m_valid_q && bus.m_ready_i) m_valid_d = 1'b0;
    if (move_acc) begin
      out_d      = acc_q;
      m_valid_d  = 1'b1;
      acc_d      = '0;
      acc_full_d = 1'b0;
    end else if (load_merged) begin
      out_d     = merged;
      m_valid_d = 1'b1;
      acc_d     = '0;
    end else if (park_merged) begin
      acc_d      = merged;
      acc_full_d = 1'b1;
    end else if (accept) begin
      acc_d = merged;
    end
  end

  // Datapath and handshake registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q      <= '0;
      out_q      <= '0;
      acc_full_q <= 1'b0;
      m_valid_q  <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      out_q      <= out_d;
      acc_full_q <= acc_full_d;
      m_valid_q  <= m_valid_d;
    end
  end

  assign bus.s_ready_o = !acc_full_q;
  assign bus.m_valid_o = m_valid_q;
  assign bus.m_data_o  = out_q;

`ifdef AXIS_WIDTH_PACKER_LAST_EN
  localparam int unsigned FillW = fill_width(Beats);

  logic             acc_last_q, m_last_q;
  logic [FillW-1:0] acc_fill_q, m_fill_q, beat_fill;

  // Beats in the closing word: a full word closes at lane N-1, so this is N.
  assign beat_fill = FillW'(cnt) + FillW'(1);

  // Sideband follows the word through the same acc/out stages.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_last_q <= 1'b0;
      acc_fill_q <= '0;
      m_last_q   <= 1'b0;
      m_fill_q   <= '0;
    end else if (move_acc) begin
      m_last_q   <= acc_last_q;
      m_fill_q   <= acc_fill_q;
      acc_last_q <= 1'b0;
      acc_fill_q <= '0;
    end else if (load_merged) begin
      m_last_q <= beat_last;
      m_fill_q <= beat_fill;
    end else if (park_merged) begin
      acc_last_q <= beat_last;
      acc_fill_q <= beat_fill;
    end
  end

  assign bus.m_last_o = m_last_q;
  assign bus.m_fill_o = m_fill_q;
`endif

endmodule

// File: tb/tb_axis_width_packer.sv
// Bench for axis_width_packer: 1->8 MSB-first and LSB-first instances share
// one stimulus and a queue model; a 4->8 instance covers backpressure.
module tb_axis_width_packer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  axis_width_packer_if #(.INPUT_WIDTH(1), .OUTPUT_WIDTH(8)) bus_a ();
  axis_width_packer_if #(.INPUT_WIDTH(1), .OUTPUT_WIDTH(8)) bus_b ();
  axis_width_packer_if #(.INPUT_WIDTH(4), .OUTPUT_WIDTH(8)) bus_c ();

  axis_width_packer #(.INPUT_WIDTH(1), .OUTPUT_WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a));
  axis_width_packer #(.INPUT_WIDTH(1), .OUTPUT_WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b));
  axis_width_packer #(.INPUT_WIDTH(4), .OUTPUT_WIDTH(8), .MSB_FIRST(1'b1)) dut_c (
    .clk(clk), .reset(reset), .bus(bus_c));

  assign bus_b.s_valid_i = bus_a.s_valid_i;
  assign bus_b.s_data_i  = bus_a.s_data_i;
  assign bus_b.m_ready_i = bus_a.m_ready_i;
`ifdef AXIS_WIDTH_PACKER_LAST_EN
  assign bus_b.s_last_i  = bus_a.s_last_i;
  assign bus_c.s_last_i  = 1'b0;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: completed words waiting to leave the DUT, oldest first.
  typedef struct {
    logic [7:0] msb;
    logic [7:0] lsb;
    int         fill;
    logic       last;
  } word_t;

  word_t exp_q[$];
  logic  beats[$];
  int    words_seen = 0;

  // Compare every cycle, then fold in the handshakes at the coming edge.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      beats.delete();
    end else begin
      check("m_valid", 32'(bus_a.m_valid_o), 32'(exp_q.size() > 0));
      check("s_ready", 32'(bus_a.s_ready_o), 32'(exp_q.size() < 2));
      if (exp_q.size() > 0 && bus_a.m_valid_o) begin
        check("data_msb", 32'(bus_a.m_data_o), 32'(exp_q[0].msb));
        check("valid_lsb", 32'(bus_b.m_valid_o), 32'd1);
        check("data_lsb", 32'(bus_b.m_data_o), 32'(exp_q[0].lsb));
`ifdef AXIS_WIDTH_PACKER_LAST_EN
        check("fill", 32'(bus_a.m_fill_o), 32'(exp_q[0].fill));
        check("last", 32'(bus_a.m_last_o), 32'(exp_q[0].last));
`endif
        if (bus_a.m_ready_i) begin
          void'(exp_q.pop_front());
          words_seen++;
        end
      end
      if (bus_a.s_valid_i && bus_a.s_ready_o) begin
        logic  last;
        word_t w;
        beats.push_back(bus_a.s_data_i[0]);
        last = 1'b0;
`ifdef AXIS_WIDTH_PACKER_LAST_EN
        last = bus_a.s_last_i;
`endif
        if (beats.size() == 8 || last) begin
          w.msb = '0;
          w.lsb = '0;
          foreach (beats[i]) begin
            w.msb[7-i] = beats[i];
            w.lsb[i]   = beats[i];
          end
          w.fill = beats.size();
          w.last = last;
          exp_q.push_back(w);
          beats.delete();
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] pat, input int n);
    for (int i = 0; i < n; i++) begin
      bus_a.s_valid_i = 1'b1;
      bus_a.s_data_i  = pat[7-i];
      step();
    end
    bus_a.s_valid_i = 1'b0;
  endtask

  initial begin
    int base;
    int cyc;
    bus_a.s_valid_i = 1'b0;
    bus_a.s_data_i  = '0;
    bus_a.m_ready_i = 1'b0;
    bus_c.s_valid_i = 1'b0;
    bus_c.s_data_i  = '0;
    bus_c.m_ready_i = 1'b0;
`ifdef AXIS_WIDTH_PACKER_LAST_EN
    bus_a.s_last_i  = 1'b0;
`endif
    reset = 1'b1;
    repeat (3) step();

    // Reset state
    check("rst_valid_a", 32'(bus_a.m_valid_o), 32'd0);
    check("rst_data_a", 32'(bus_a.m_data_o), 32'd0);
    check("rst_ready_a", 32'(bus_a.s_ready_o), 32'd1);
    check("rst_valid_c", 32'(bus_c.m_valid_o), 32'd0);
    check("rst_ready_c", 32'(bus_c.s_ready_o), 32'd1);
`ifdef AXIS_WIDTH_PACKER_LAST_EN
    check("rst_fill_a", 32'(bus_a.m_fill_o), 32'd0);
    check("rst_last_a", 32'(bus_a.m_last_o), 32'd0);
`endif
    reset = 1'b0;
    step();

    // Basic packing and lane order: 1,0,1,1,0,0,1,0
    bus_a.m_ready_i = 1'b1;
    send_bits(8'hB2, 8);
    check("basic_valid", 32'(bus_a.m_valid_o), 32'd1);
    check("basic_msb", 32'(bus_a.m_data_o), 32'h0B2);
    check("basic_lsb", 32'(bus_b.m_data_o), 32'h04D);
    step();
    check("basic_one_cycle", 32'(bus_a.m_valid_o), 32'd0);

    // Reset mid-word discards the partial word
    send_bits(8'hE0, 3);
    reset = 1'b1;
    #2;
    check("midrst_valid", 32'(bus_a.m_valid_o), 32'd0);
    check("midrst_ready", 32'(bus_a.s_ready_o), 32'd1);
    step();
    reset = 1'b0;
    step();
    send_bits(8'hFF, 8);
    check("after_rst_data", 32'(bus_a.m_data_o), 32'h0FF);
    check("after_rst_lsb", 32'(bus_b.m_data_o), 32'h0FF);
    step();

`ifdef AXIS_WIDTH_PACKER_LAST_EN
    // Packet end closes a partial word; the next word starts at lane 0
    for (int i = 0; i < 3; i++) begin
      bus_a.s_valid_i = 1'b1;
      bus_a.s_data_i  = 1'b1;
      bus_a.s_last_i  = (i == 2);
      step();
    end
    bus_a.s_valid_i = 1'b0;
    bus_a.s_last_i  = 1'b0;
    check("pkt_data", 32'(bus_a.m_data_o), 32'h0E0);
    check("pkt_fill", 32'(bus_a.m_fill_o), 32'd3);
    check("pkt_last", 32'(bus_a.m_last_o), 32'd1);
    check("pkt_lsb", 32'(bus_b.m_data_o), 32'h007);
    send_bits(8'h80, 8);
    check("pkt_next_data", 32'(bus_a.m_data_o), 32'h080);
    check("pkt_next_fill", 32'(bus_a.m_fill_o), 32'd8);
    check("pkt_next_last", 32'(bus_a.m_last_o), 32'd0);
    step();
`endif

    // Stalled output on the 4->8 instance
    for (int k = 1; k <= 4; k++) begin
      bus_c.s_valid_i = 1'b1;
      bus_c.s_data_i  = 4'(k);
      step();
    end
    check("stall_ready", 32'(bus_c.s_ready_o), 32'd0);
    check("stall_valid", 32'(bus_c.m_valid_o), 32'd1);
    check("stall_data", 32'(bus_c.m_data_o), 32'h012);
    bus_c.s_data_i = 4'd5;
    step();
    step();
    check("stall_hold_data", 32'(bus_c.m_data_o), 32'h012);
    check("stall_hold_ready", 32'(bus_c.s_ready_o), 32'd0);
    bus_c.m_ready_i = 1'b1;
    step();
    bus_c.m_ready_i = 1'b0;
    check("recover_data", 32'(bus_c.m_data_o), 32'h034);
    check("recover_valid", 32'(bus_c.m_valid_o), 32'd1);
    check("recover_ready", 32'(bus_c.s_ready_o), 32'd1);
    step();
    bus_c.s_valid_i = 1'b0;
    check("n5_ready", 32'(bus_c.s_ready_o), 32'd1);
    check("n5_data_held", 32'(bus_c.m_data_o), 32'h034);
    bus_c.m_ready_i = 1'b1;
    bus_c.s_valid_i = 1'b1;
    bus_c.s_data_i  = 4'd6;
    step();
    bus_c.s_valid_i = 1'b0;
    bus_c.m_ready_i = 1'b0;
    check("n56_data", 32'(bus_c.m_data_o), 32'h056);
    check("n56_valid", 32'(bus_c.m_valid_o), 32'd1);
    bus_c.m_ready_i = 1'b1;
    step();
    check("n56_drained", 32'(bus_c.m_valid_o), 32'd0);

    // Random valid/ready against the model, 1000 words
    base = words_seen;
    cyc  = 0;
    while (words_seen - base < 1000 && cyc < 60000) begin
      int mode;
      mode = (cyc / 128) % 3;
      bus_a.s_valid_i = ($urandom_range(3) != 0);
      bus_a.s_data_i  = 1'($urandom_range(1));
      bus_a.m_ready_i = (mode == 0) ? 1'b1 :
                        (mode == 1) ? ($urandom_range(1) == 0) : ($urandom_range(3) == 0);
`ifdef AXIS_WIDTH_PACKER_LAST_EN
      bus_a.s_last_i  = ($urandom_range(15) == 0);
`endif
      step();
      cyc++;
    end
    check("rand_words", 32'(words_seen - base), 32'd1000);
    bus_a.s_valid_i = 1'b0;
    bus_a.m_ready_i = 1'b1;
`ifdef AXIS_WIDTH_PACKER_LAST_EN
    bus_a.s_last_i  = 1'b0;
`endif
    repeat (4) step();
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
